// File: rtl/strand_instruction_fifo.sv
`default_nettype none
// ============================================================================
// Module      : strand_instruction_fifo
// Description : Per-strand instruction buffer between fetch and strand select.
//               STRAND_COUNT independent circular queues of DEPTH entries that
//               share one strand-tagged enqueue port. Each strand has its own
//               dequeue and flush. Overflow and underflow are reported through
//               sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module strand_instruction_fifo #(
    parameter int WIDTH           = 64,
    parameter int DEPTH           = 4,
    parameter int ADDR_WIDTH      = 2,
    parameter int STRAND_COUNT    = 4,
    parameter int STRAND_ID_WIDTH = 2,
    parameter int REQUEST_MARGIN  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [STRAND_COUNT-1:0]       flush_i,
    input  logic                          enqueue_i,
    input  logic [STRAND_ID_WIDTH-1:0]    enqueue_strand_i,
    input  logic [WIDTH-1:0]              value_i,
    input  logic [STRAND_COUNT-1:0]       dequeue_i,
    output logic [STRAND_COUNT-1:0]       instruction_request_o,
    output logic [STRAND_COUNT-1:0]       instruction_ready_o,
    output logic [STRAND_COUNT*WIDTH-1:0] value_o,
    output logic [STRAND_COUNT-1:0]       overflow_o,
    output logic [STRAND_COUNT-1:0]       underflow_o
);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    localparam int                PTR_W      = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0]  c_FULL     = PTR_W'(DEPTH);
    // Fetch may issue only while this many entries or fewer will be held.
    localparam logic [PTR_W-1:0]  c_REQ_MAX  = PTR_W'(DEPTH - 1 - REQUEST_MARGIN);

    for (genvar s = 0; s < STRAND_COUNT; s++) begin : g_strand
        logic [PTR_W-1:0] rptr_q, rptr_d;
        logic [PTR_W-1:0] wptr_q, wptr_d;
        logic             ovf_q, ovf_d;
        logic             unf_q, unf_d;
        logic [WIDTH-1:0] mem_q [DEPTH];

        logic [PTR_W-1:0] w_count;
        logic [PTR_W-1:0] w_count_nxt;
        logic             w_empty;
        logic             w_full;
        logic             w_enq;
        logic             w_deq;
        logic             w_enq_ok;
        logic             w_deq_ok;

        // Accept/reject decisions and next pointer/flag values for this strand.
        always_comb begin
            w_count     = wptr_q - rptr_q;
            w_empty     = (rptr_q == wptr_q);
            w_full      = (rptr_q[ADDR_WIDTH-1:0] == wptr_q[ADDR_WIDTH-1:0]) &&
                          (rptr_q[ADDR_WIDTH] != wptr_q[ADDR_WIDTH]);
            w_enq       = enqueue_i && (enqueue_strand_i == STRAND_ID_WIDTH'(s));
            w_deq       = dequeue_i[s];
            // A full queue can still take a write when it is popped the same
            // cycle; full implies non-empty, so the pop is always accepted.
            w_deq_ok    = !flush_i[s] && w_deq && !w_empty;
            w_enq_ok    = !flush_i[s] && w_enq && (!w_full || w_deq);
            rptr_d      = rptr_q;
            wptr_d      = wptr_q;
            ovf_d       = ovf_q;
            unf_d       = unf_q;
            w_count_nxt = '0;
            if (flush_i[s]) begin
                // Flush discards same-cycle traffic silently; flags persist.
                rptr_d = '0;
                wptr_d = '0;
            end else begin
                w_count_nxt = w_count + PTR_W'(w_enq_ok) - PTR_W'(w_deq_ok);
                if (w_deq_ok) rptr_d = rptr_q + PTR_W'(1);
                if (w_enq_ok) wptr_d = wptr_q + PTR_W'(1);
                if (w_enq && !w_enq_ok) ovf_d = 1'b1;
                if (w_deq && w_empty)   unf_d = 1'b1;
            end
        end

        // Pointer and sticky error flag registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                rptr_q <= '0;
                wptr_q <= '0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end else begin
                rptr_q <= rptr_d;
                wptr_q <= wptr_d;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end

        // Entry storage; contents after reset are hidden by the output mask.
        always_ff @(posedge clk) begin
            if (!reset && w_enq_ok) begin
                mem_q[wptr_q[ADDR_WIDTH-1:0]] <= value_i;
            end
        end

        assign instruction_ready_o[s]   = !w_empty;
        assign instruction_request_o[s] = (w_count_nxt <= c_REQ_MAX);
        assign value_o[s*WIDTH +: WIDTH] = w_empty ? '0 : mem_q[rptr_q[ADDR_WIDTH-1:0]];
        assign overflow_o[s]            = ovf_q;
        assign underflow_o[s]           = unf_q;
    end

endmodule
`default_nettype wire

// File: doc/strand_instruction_fifo.md
# strand_instruction_fifo

Per-strand instruction buffer between the instruction fetch stage and strand select, replacing the single-channel shift FIFO. It holds STRAND_COUNT independent circular queues of DEPTH entries each. The queues share one enqueue port tagged with a strand ID and have independent dequeue and flush per strand. Overflow and underflow raise sticky error flags instead of stopping simulation.

## Interface
- WIDTH, 64, instruction bundle width in bits
- DEPTH, 4, entries per strand; power of two, >= 2
- ADDR_WIDTH, 2, log2(DEPTH)
- STRAND_COUNT, 4, number of strands/queues
- STRAND_ID_WIDTH, 2, log2(STRAND_COUNT)
- REQUEST_MARGIN, 1, free slots held back for fetch latency; 0 <= REQUEST_MARGIN < DEPTH
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- flush_i  in  STRAND_COUNT  per-strand flush (branch/rollback)
- enqueue_i  in  1  write value_i into the queue selected by enqueue_strand_i
- enqueue_strand_i  in  STRAND_ID_WIDTH  target strand of the enqueue
- value_i  in  WIDTH  instruction bundle to enqueue
- dequeue_i  in  STRAND_COUNT  per-strand pop of the head entry
- instruction_request_o  out  STRAND_COUNT  fetch may issue for this strand
- instruction_ready_o  out  STRAND_COUNT  strand queue is non-empty
- value_o  out  STRAND_COUNT*WIDTH  head entry per strand; strand s occupies bits [s*WIDTH +: WIDTH]
- overflow_o  out  STRAND_COUNT  sticky: enqueue was attempted to a full queue
- underflow_o  out  STRAND_COUNT  sticky: dequeue was attempted on an empty queue

## Operation
- Each strand has storage of DEPTH x WIDTH, plus a read pointer and a write pointer of ADDR_WIDTH+1 bits each.
- The extra pointer bit is a wrap bit. count = wptr - rptr, taken modulo 2^(ADDR_WIDTH+1), with range 0..DEPTH.
- Empty: pointers equal. Full: low bits equal and wrap bits differ.
- Pointers wrap naturally. Entry index is the low ADDR_WIDTH bits.
- instruction_ready_o[s] = (count[s] != 0). It depends on registered state only.
- value_o[s] = storage[s][rptr low bits] when ready, else all zeros. Output is never X.
- count_nxt[s] is the count after this cycle's accepted operations.
- instruction_request_o[s] = (count_nxt[s] <= DEPTH-1-REQUEST_MARGIN). It is combinational from the current cycle's inputs, so it drops one cycle early, as today.
- Priority per strand, highest first: reset, then flush_i[s], then enqueue/dequeue.
- reset: all pointers go to 0. overflow_o and underflow_o clear. Storage contents are don't-care; value_o masking hides them.
- flush_i[s]: rptr[s] and wptr[s] go to 0. An enqueue or dequeue to s in the same cycle is discarded with no error. Error flags are kept. Other strands are unaffected.
- Enqueue to s, not full: write storage at wptr, then wptr+1.
- Enqueue to s, full, no dequeue[s] the same cycle: entry dropped, overflow_o[s] <= 1.
- Enqueue to s, full, with dequeue[s] the same cycle: both accepted, count stays DEPTH.
- Dequeue s, non-empty: rptr+1.
- Dequeue s, empty: ignored, underflow_o[s] <= 1. A same-cycle enqueue to s is still accepted, giving count 1.
- Enqueues and dequeues to different strands in the same cycle are fully independent.

## Timing
- Reset values: instruction_ready_o=0, value_o=0, overflow_o=0, underflow_o=0.
- After reset, instruction_request_o is all ones whenever no enqueue is asserted.
- Enqueue at edge N: ready_o and value_o reflect the entry from cycle N+1. There is no bypass from value_i to value_o.
- Dequeue at edge N: the next entry, or ready=0, is visible at N+1.
- instruction_request_o has zero latency: it is combinational from enqueue_i, enqueue_strand_i, dequeue_i, flush_i and state.
- Flush at edge N: ready_o[s]=0 at N+1, and request_o[s]=1 from N+1.
- Error flags assert at N+1 after the offending edge and hold until reset.
- Throughput: one enqueue per cycle total, and one dequeue per strand per cycle.

## Test plan
- Reset, then idle.
  - All outputs match their reset values; request_o=4'b1111.
- Strand 2, DEPTH=4, MARGIN=1: enqueue A,B,C,D over 4 cycles.
  - request_o[2] drops in the cycle C is enqueued (count_nxt=3).
  - ready_o[2]=1 from the cycle after A; value_o[2]=A.
  - Dequeue 4 times: outputs B, C, D, then ready_o[2]=0 and value_o[2]=0.
- Wrap-around: on strand 0, interleave 10 enqueues and dequeues keeping count at 1..3.
  - Order is preserved across the pointer wrap.
  - No error flags.
- Full strand 1 (4 entries) plus enqueue E with no dequeue: E dropped, overflow_o[1]=1, value_o[1] unchanged.
- Same as above but with dequeue_i[1] in the same cycle: E accepted, count stays 4, no overflow. E appears after 3 more dequeues.
- Empty strand 3:
  - dequeue alone: underflow_o[3]=1.
  - Then flush strand 0 holding 2 entries while enqueueing to 0 in the same cycle: ready_o[0]=0 next cycle, no overflow, and strands 1-3 are unchanged.
